// File: rtl/vid_pll_ctrl_pkg.sv
// vid_pll_ctrl_pkg: state encoding and 27 MHz default counts for the video PLL reset sequencer
package vid_pll_ctrl_pkg;
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;
  localparam int RST_HOLD_DEF     = 270;
  localparam int LOCK_STABLE_DEF  = 2700;
  localparam int LOCK_TIMEOUT_DEF = 27000;
  localparam int MAX_RETRIES_DEF  = 3;
  localparam int CNT_W_DEF        = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/vid_pll_reset_ctrl.sv
// vid_pll_reset_ctrl: PLL reset sequencer with lock qualification, bounded retry and sticky failure
module vid_pll_reset_ctrl
  import vid_pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = RST_HOLD_DEF,
  parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_DEF,
  parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_DEF,
  parameter int MAX_RETRIES         = MAX_RETRIES_DEF,
  parameter int CNT_W               = CNT_W_DEF
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       vid_rst_n,
  output logic       lock_lost,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);
  pll_state_e st, nxt;
  logic [CNT_W-1:0] cnt;
  logic locked_s, lost_d;
  logic [1:0] retry_d, retry_inc;
  sync_2ff u_sync (.clk(refclk), .rst_n(rst_n), .d(pll_locked), .q(locked_s));
  assign retry_inc = (retry_cnt == 2'd3) ? retry_cnt : retry_cnt + 2'd1;
  assign state = st;
  always_comb begin
    nxt     = st;
    retry_d = retry_cnt;
    lost_d  = 1'b0;
    if (restart) begin
      nxt     = RESET_PLL;
      retry_d = '0;
    end else begin
      case (st)
        RESET_PLL: nxt = (cnt == HOLD_LAST) ? WAIT_LOCK : RESET_PLL;
        WAIT_LOCK: begin
          if (locked_s) nxt = STABILIZE;
          else if (cnt == TO_LAST) begin
            retry_d = retry_inc;
            nxt     = (retry_inc == RETRY_MAX) ? FAIL : RESET_PLL;
          end
        end
        STABILIZE: begin
          if (!locked_s) nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST) begin
            nxt     = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            nxt    = RESET_PLL;
            lost_d = 1'b1;
          end
        end
        FAIL:    nxt = FAIL;
        default: nxt = RESET_PLL;
      endcase
    end
  end
  // outputs decode the next state so they move on the same edge as state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      vid_rst_n <= 1'b0;
      lock_lost <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      st        <= nxt;
      cnt       <= (restart || nxt != st) ? '0 : cnt + 1'b1;
      pll_rst   <= (nxt == RESET_PLL) || (nxt == FAIL);
      vid_rst_n <= (nxt == RUN);
      lock_lost <= lost_d;
      fail      <= (nxt == FAIL);
      retry_cnt <= retry_d;
    end
  end
endmodule

// File: tb/tb_vid_pll_reset_ctrl.sv
// tb_vid_pll_reset_ctrl: scoreboard bench with a timestamp-based reference model of the PLL reset sequencer
module tb_vid_pll_reset_ctrl;
  import vid_pll_ctrl_pkg::*;
  localparam int HOLD = 4, STABLE = 8, TO = 20, MAXR = 2;
  typedef struct packed {
    logic [2:0] st;
    logic       prst;
    logic       vrst;
    logic       lost;
    logic       fl;
    logic [1:0] rc;
  } exp_t;
  localparam exp_t RST_EXP = '{st: 3'd0, prst: 1'b1, vrst: 1'b0, lost: 1'b0, fl: 1'b0, rc: 2'd0};
  logic refclk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, restart = 1'b0;
  logic pll_rst, vid_rst_n, lock_lost, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;
  int total = 0, bad = 0;
  exp_t q[$];
  logic sampled[$];
  int n, t_enter, mretry;
  pll_state_e ms;

  vid_pll_reset_ctrl #(
    .RST_HOLD_CYCLES(HOLD), .LOCK_STABLE_CYCLES(STABLE), .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MAXR), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .vid_rst_n(vid_rst_n), .lock_lost(lock_lost), .fail(fail),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 refclk = ~refclk;

  function automatic exp_t dut_out();
    return '{st: state, prst: pll_rst, vrst: vid_rst_n, lost: lock_lost, fl: fail, rc: retry_cnt};
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    n = 0; t_enter = 0; mretry = 0; ms = RESET_PLL;
    sampled.delete();
  endfunction

  // n counts edges since reset release; a state entered at edge t lasts until edge t+limit
  function automatic void model_step(input logic pl, input logic rs);
    logic ls, lost;
    int age;
    pll_state_e ns;
    n++;
    sampled.push_back(pl);
    ls   = (n >= 3) ? sampled[n-3] : 1'b0;
    age  = n - t_enter;
    ns   = ms;
    lost = 1'b0;
    if (rs) begin
      ns = RESET_PLL; mretry = 0;
    end else if (ms == RESET_PLL && age == HOLD) ns = WAIT_LOCK;
    else if (ms == WAIT_LOCK && ls) ns = STABILIZE;
    else if (ms == WAIT_LOCK && age == TO) begin
      mretry = (mretry < 3) ? mretry + 1 : 3;
      ns = (mretry == MAXR) ? FAIL : RESET_PLL;
    end else if (ms == STABILIZE && !ls) ns = WAIT_LOCK;
    else if (ms == STABILIZE && age == STABLE) begin
      ns = RUN; mretry = 0;
    end else if (ms == RUN && !ls) begin
      ns = RESET_PLL; lost = 1'b1;
    end
    if (rs || ns != ms) t_enter = n;
    ms = ns;
    q.push_back('{st: ns, prst: (ns == RESET_PLL || ns == FAIL), vrst: (ns == RUN),
                  lost: lost, fl: (ns == FAIL), rc: 2'(mretry)});
  endfunction

  task automatic step(input logic pl, input logic rs);
    @(negedge refclk);
    rst_n = 1'b1; pll_locked = pl; restart = rs;
    model_step(pl, rs);
  endtask

  task automatic obs();
    @(posedge refclk);
    #2;
  endtask

  task automatic reset_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge refclk);
      rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
      q.push_back(RST_EXP);
    end
    model_reset();
  endtask

  task automatic do_async_reset();
    @(negedge refclk);
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    #1;
    chk("async_rst_outputs", int'(dut_out()), int'(RST_EXP));
    q.push_back(RST_EXP);
    reset_cycles(2);
  endtask

  task automatic wait_vid(output int c);
    c = 0;
    do begin
      step(1'b1, 1'b0); obs(); c++;
    end while (!vid_rst_n && c < 300);
    chk("wait_vid_bound", int'(vid_rst_n), 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge refclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("scoreboard", int'(dut_out()), int'(e));
      end
    end
  end

  initial begin : stim
    int c, len, k;
    int lens_lo[6] = '{1, 2, 5, 12, 30, 60};
    int lens_hi[6] = '{1, 3, 9, 20, 60, 120};
    logic pl;
    reset_cycles(3);
    // nominal: pll_rst high 4 cycles, vid_rst_n 11 cycles after lock edge
    c = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0); obs();
      if (pll_rst && c == i + 1) c++;
    end
    chk("nominal_pll_rst_len", c, HOLD);
    wait_vid(c);
    chk("nominal_vid_latency", c, 2 + STABLE + 1);
    chk("nominal_retry", int'(retry_cnt), 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    // restart coincides with locked_s falling in RUN
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1); obs();
    chk("restart_prio_state", int'(state), 0);
    chk("restart_prio_no_lost", int'(lock_lost), 0);
    chk("restart_prio_retry", int'(retry_cnt), 0);
    wait_vid(c);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    // lock lost in RUN, then hold unlocked until FAIL
    c = 0;
    do begin
      step(1'b0, 1'b0); obs(); c++;
    end while (vid_rst_n && c < 10);
    chk("loss_latency", c, 3);
    chk("loss_lock_lost", int'(lock_lost), 1);
    chk("loss_pll_rst", int'(pll_rst), 1);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
    obs();
    chk("fail_state", int'(state), 4);
    chk("fail_flag", int'(fail), 1);
    chk("fail_retry", int'(retry_cnt), MAXR);
    chk("fail_pll_rst", int'(pll_rst), 1);
    step(1'b0, 1'b1); obs();
    chk("fail_restart_clear", int'(fail), 0);
    chk("fail_restart_state", int'(state), 0);
    // async reset while in STABILIZE
    k = 0;
    do begin
      step(1'b1, 1'b0); obs(); k++;
    end while (state != 3'd2 && k < 100);
    chk("reach_stabilize", int'(state), 2);
    do_async_reset();
    // unstable lock: brief high, drop, then steady
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    wait_vid(c);
    chk("unstable_vid_latency", c, 2 + STABLE + 1);
    // timeout from a fresh reset: pulses every 24 cycles, then FAIL
    do_async_reset();
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
    obs();
    chk("timeout_fail", int'(fail), 1);
    step(1'b1, 1'b1);
    // randomized segments with occasional restart and async reset
    for (int seg = 0; seg < 120; seg++) begin
      pl  = 1'($urandom_range(0, 1));
      len = pl ? lens_hi[$urandom_range(0, 5)] : lens_lo[$urandom_range(0, 5)];
      for (int i = 0; i < len; i++) step(pl, $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) do_async_reset();
    end
    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(posedge refclk); k++;
    end
    #3;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vid_pll_reset_ctrl.md
# vid_pll_reset_ctrl

Reset sequencer and lock supervisor for the video pixel-clock PLL, which makes 74.25 MHz from the 27 MHz reference. The block runs on the free-running 27 MHz reference clock, drives the PLL reset, qualifies `locked`, and releases a reset to the video pipeline only after lock has been stable. It also detects loss of lock, retries a bounded number of times, and reports a sticky failure.

## Interface
- `RST_HOLD_CYCLES`, 270: cycles `pll_rst` is held high per attempt (10 µs at 27 MHz).
- `LOCK_STABLE_CYCLES`, 2700: consecutive synchronized-locked cycles required before release (100 µs).
- `LOCK_TIMEOUT_CYCLES`, 27000: cycles allowed for lock after `pll_rst` falls (1 ms).
- `MAX_RETRIES`, 3: failed attempts tolerated before FAIL (≥1).
- `CNT_W`, 16: cycle-counter width; must hold the largest count parameter.
- `refclk  in  1`: 27 MHz reference clock, the only clock.
- `rst_n  in  1`: reset, asynchronous assert, active-low.
- `pll_locked  in  1`: PLL `locked`, asynchronous; synchronized internally.
- `restart  in  1`: one-cycle request to re-run the full sequence (e.g. after reconfiguration).
- `pll_rst  out  1`: to PLL `rst`, active-high.
- `vid_rst_n  out  1`: video-domain reset, active-low, in the `refclk` domain. Consumers resynchronize it to the 74.25 MHz clock.
- `lock_lost  out  1`: one-cycle pulse when lock drops in RUN.
- `fail  out  1`: sticky; retries are exhausted.
- `retry_cnt  out  2`: failed attempts in the current sequence, saturating.
- `state  out  3`: current state encoding, for status registers.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to give `locked_s`.
- A single counter is cleared on every state entry. A state with limit N exits when the count equals N-1, so the state lasts N cycles.
- States and transitions:
  - RESET_PLL: `pll_rst`=1. Exits to WAIT_LOCK after `RST_HOLD_CYCLES`.
  - WAIT_LOCK: `pll_rst`=0.
    - `locked_s`=1 → STABILIZE.
    - Timeout → increment `retry_cnt`. If the new value equals `MAX_RETRIES` → FAIL, else → RESET_PLL.
  - STABILIZE:
    - `locked_s`=0 → WAIT_LOCK. The counter clears, so the timeout restarts.
    - `LOCK_STABLE_CYCLES` consecutive locked cycles → RUN, and `retry_cnt` clears.
  - RUN: `vid_rst_n`=1. `locked_s`=0 → pulse `lock_lost`, go to RESET_PLL, and `retry_cnt` is unchanged.
  - FAIL: `fail`=1, `pll_rst`=1 (PLL parked). Stays here until `restart`.
- `restart` works in every state:
  - next state is RESET_PLL;
  - `retry_cnt` and `fail` clear;
  - `restart` has priority over every other transition in the same cycle, including a lock drop in RUN. In that case `lock_lost` is not pulsed.
- `vid_rst_n`=1 only while in RUN. It is 0 in every other state.
- All outputs are registered. They are decoded from next-state, so they change on the same edge as `state`.

## Timing
- Reset values: `state`=RESET_PLL, `pll_rst`=1, `vid_rst_n`=0, `lock_lost`=0, `fail`=0, `retry_cnt`=0, counter=0.
- Asserting `rst_n` mid-sequence forces the reset values immediately (asynchronously). On release, the sequence restarts from RESET_PLL with a full hold period.
- Synchronizer latency: a `pll_locked` edge reaches `locked_s` 2 cycles later.
  - Lock drop in RUN to `vid_rst_n`=0 and `pll_rst`=1: 3 edges.
  - STABILIZE exit: `vid_rst_n` rises on the edge that enters RUN.
- Minimum time from `rst_n` release to `vid_rst_n`=1, with a PLL that locks instantly: `RST_HOLD_CYCLES` + 2 + `LOCK_STABLE_CYCLES` + 1 cycles.
- Lock glitches shorter than one `refclk` period may be missed. This is acceptable; the PLL `locked` is level-valid.

## Structure
- Package `vid_pll_ctrl_pkg`:
  - state enum: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4;
  - default count constants for 27 MHz.
- Sub-module `sync_2ff`: a 1-bit, two-flop synchronizer with async active-low reset to 0. It is reusable across the codebase.
- FSM and counter stay in the top level.

## Test plan
Use `RST_HOLD_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=20, `MAX_RETRIES`=2.
- Nominal lock: release `rst_n`, raise `pll_locked` 10 cycles later.
  - Expect `pll_rst` high for exactly 4 cycles.
  - Expect `vid_rst_n` to rise 2+8+1 cycles after the `pll_locked` edge, with `retry_cnt`=0.
- Unstable lock: toggle `pll_locked` high for 5 cycles, low, then high for good. Expect a return to WAIT_LOCK, and `vid_rst_n` to rise only after 8 consecutive locked cycles.
- Timeout and fail: hold `pll_locked`=0.
  - Expect two 4-cycle `pll_rst` pulses 24 cycles apart.
  - Expect `retry_cnt` to reach 2, then `fail`=1, `state`=4, and `pll_rst`=1 steady.
- Loss of lock in RUN: drop `pll_locked`. Expect `lock_lost` for 1 cycle, `vid_rst_n`=0 and `pll_rst`=1 within 3 cycles, then a full re-sequence.
- Restart priority: in RUN, pulse `restart` in the same cycle that `locked_s` falls. Expect RESET_PLL, no `lock_lost` pulse, and `retry_cnt`=0. Pulsing `restart` in FAIL clears `fail`.
- Async reset mid-STABILIZE: assert `rst_n`. Expect all outputs at reset values before the next `refclk` edge.
